// File: rtl/bitwise_pkg.sv
// bitwise_pkg: definitions shared by bitwise_unit and its result buffer.
//   op_e              - 3-bit operation select carried on in_op
//   BW_WIDTH_DEFAULT  - default operand/result width
//   BW_DEPTH_DEFAULT  - default result buffer depth (power of two)
package bitwise_pkg;

  localparam int BW_WIDTH_DEFAULT = 32;
  localparam int BW_DEPTH_DEFAULT = 2;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NOR    = 3'd3,
    OP_NAND   = 3'd4,
    OP_XNOR   = 3'd5,
    OP_ANDN   = 3'd6,  // a & ~b
    OP_PASS_A = 3'd7
  } op_e;

endpackage

// File: rtl/bitwise_fifo.sv
// bitwise_fifo: result buffer for bitwise_unit, DEPTH entries of W bits.
// Ports:
//   clock, reset_n  - rising-edge clock, asynchronous active-low reset
//   push, wdata     - write an entry (ignored while full)
//   pop             - drop the head entry (ignored while empty)
//   rdata           - head entry (zero after reset)
//   full, empty     - registered occupancy status
// Handshake: the owner raises push only when it has seen full=0 and pop only
// when it has seen empty=0; both take effect on the same rising edge.
module bitwise_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // the increment wrap modulo DEPTH for free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bitwise_unit.sv
// bitwise_unit: pipelined bitwise ALU with an accumulator and a result buffer.
// Ports:
//   clock, reset_n        - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     - request handshake; accept when both are 1
//   in_a, in_b, in_op     - operands and op select (bitwise_pkg::op_e)
//   in_acc                - use accumulator in place of in_b and write result back
//   acc_clear             - clear accumulator at the next edge (wins over write-back)
//   out_valid/out_ready   - result handshake; pop when both are 1
//   out_data, out_zero    - head result and its all-zero flag
//   out_parity            - XOR of head result (only with BITWISE_UNIT_PARITY_EN)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends combinationally on the other side's valid/ready.
// Build option: define BITWISE_UNIT_PARITY_EN to add out_parity and its storage.
module bitwise_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH = BW_WIDTH_DEFAULT,
  parameter int DEPTH = BW_DEPTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITWISE_UNIT_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_zero
);

`ifdef BITWISE_UNIT_PARITY_EN
  localparam int FLAG_W = 2;  // {parity, zero}
`else
  localparam int FLAG_W = 1;  // {zero}
`endif
  localparam int EW = WIDTH + FLAG_W;

  op_e             op;
  logic            rdy_q;      // low through reset, high from the first edge after
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic            full;
  logic            empty;
  logic            accept;
  logic            pop;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;

  assign op        = op_e'(in_op);
  assign operand_b = in_acc ? acc_q : in_b;

  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = in_a & operand_b;
      OP_OR:     result = in_a | operand_b;
      OP_XOR:    result = in_a ^ operand_b;
      OP_NOR:    result = ~(in_a | operand_b);
      OP_NAND:   result = ~(in_a & operand_b);
      OP_XNOR:   result = ~(in_a ^ operand_b);
      OP_ANDN:   result = in_a & ~operand_b;
      OP_PASS_A: result = in_a;
      default:   result = '0;
    endcase
  end

`ifdef BITWISE_UNIT_PARITY_EN
  assign wdata = {^result, ~|result, result};
`else
  assign wdata = {~|result, result};
`endif

  assign in_ready = rdy_q & ~full;
  assign accept   = in_valid & in_ready;
  assign pop      = ~empty & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b0;
      acc_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (acc_clear)             acc_q <= '0;
      else if (accept && in_acc) acc_q <= result;
    end
  end

  bitwise_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (accept),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty)
  );

  // Outputs are forced to zero while empty so stale entries never show.
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : rdata[WIDTH-1:0];
  assign out_zero  = ~empty & rdata[WIDTH];
`ifdef BITWISE_UNIT_PARITY_EN
  assign out_parity = ~empty & rdata[WIDTH+1];
`endif

endmodule

// File: doc/bitwise_unit.md
BITWISE_UNIT -- requirements
Module: bitwise_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, >= 1.
REQ-002 Parameter DEPTH, default 2: result buffer entries, power of two, >= 2.
REQ-003 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1: operation request present.
REQ-006 Port in_ready  output  1: unit can accept a request this cycle.
REQ-007 Port in_a  input  WIDTH: operand A.
REQ-008 Port in_b  input  WIDTH: operand B; ignored when in_acc=1.
REQ-009 Port in_op  input  3: operation select, encoding per REQ-015.
REQ-010 Port in_acc  input  1: accumulate mode; the accumulator register replaces B and receives the result.
REQ-011 Port acc_clear  input  1: synchronous clear of the accumulator.
REQ-012 Port out_valid  output  1: result available at the buffer head.
REQ-013 Port out_ready  input  1: consumer takes the head result.
REQ-014 Port out_data  output  WIDTH: head result; out_zero  output  1: head result is all-zero.

Function
REQ-015 Encoding: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (A & ~B), 7 PASS_A.
REQ-016 Accept occurs when in_valid && in_ready; the result is computed bitwise over all WIDTH bits with no carries or cross-bit dependence.
REQ-017 in_ready = !full; it depends only on registered state, with no combinational path from out_ready.
REQ-018 Latency: a result accepted at edge N into an empty buffer is presented with out_valid=1 at edge N (visible in cycle N+1).
REQ-019 Throughput: one accept per cycle while not full; results leave in acceptance order.
REQ-020 Pop occurs when out_valid && out_ready; out_data and out_zero are undefined-free and hold steady while out_valid && !out_ready.
REQ-021 Full buffer: in_ready=0 and in_valid is ignored; no overwrite occurs.
REQ-022 Simultaneous pop and accept on a full buffer: still not accepted, because in_ready was 0.
REQ-023 Simultaneous push and pop on a non-full buffer: occupancy is unchanged.
REQ-024 Read and write pointers wrap modulo DEPTH.
REQ-025 Accumulate accept: result = op(in_a, acc); acc <= result at the same edge, so back-to-back accumulate ops chain with no bubble.
REQ-026 acc_clear: acc <= 0 at the next edge and takes priority over a same-cycle accumulate write; that accepted op still uses and reports the pre-clear acc value.
REQ-027 A non-accumulate accept leaves acc unchanged.

Reset
REQ-028 While reset_n=0: buffer empty, pointers 0, acc 0, in_ready=0, out_valid=0, out_data=0, out_zero=0.
REQ-029 At the first edge after deassertion, in_ready=1.
REQ-030 Reset mid-operation discards all buffered results and the accumulator with no partial output.

Configuration
REQ-031 Macro BITWISE_UNIT_PARITY_EN defined: adds port out_parity  output  1, the even parity (XOR) of the head result, stored per entry alongside the data.
REQ-032 Macro undefined: the port and its storage are absent; all other behaviour is identical.

Structure
REQ-033 Shared package bitwise_pkg holds the 3-bit op enum typedef, the op constants and the default WIDTH/DEPTH.
REQ-034 Result buffer is one sub-module, bitwise_fifo (parametrised WIDTH+flags, DEPTH); the op decode stays in the top level.

Verification
REQ-035 WIDTH=32: accept op=1, A=0x0000_FF00, B=0x00FF_0000 -> next cycle out_valid=1, out_data=0x00FF_FF00, out_zero=0.
REQ-036 Sweep all ops with A=0xF0F0_F0F0, B=0xFF00_FF00 -> results 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F, 0x0FFF0FFF, 0xF00FF00F, 0x00F000F0, 0xF0F0F0F0.
REQ-037 DEPTH=2 with out_ready=0: accept 2 ops -> in_ready=0; third in_valid is held and dropped until one pop, then accepted; order is preserved across wrap.
REQ-038 Accumulate OR A=0x1, 0x2, 0x4 on consecutive cycles -> outputs 0x1, 0x3, 0x7; then acc_clear with an accumulate OR A=0x8 -> output 0xF, acc=0, next accumulate OR 0x10 -> 0x10.
REQ-039 Assert reset_n=0 with 2 buffered results -> out_valid=0 asynchronously; after release the buffer is empty and acc=0.
REQ-040 PARITY_EN build: result 0x0000_0007 -> out_parity=1; result 0x3 -> out_parity=0.
